// File: rtl/scan_chain_lanes.sv
// scan_chain_lanes: N-bit scan register split into L parallel lanes with capture, shadow update and frame counter.
module scan_chain_lanes #(
   parameter int N = 64,
   parameter int L = 4,
   localparam int M = N / L,
   localparam int CW = $clog2(M + 1)
) (
   input  logic          scan_clk,
   input  logic          scan_rst,
   input  logic          scan_en,
   input  logic [L-1:0]  scan_in,
   output logic [L-1:0]  scan_out,
   input  logic          capture_en,
   input  logic [N-1:0]  cap_din,
   input  logic          update_en,
   input  logic [N-1:0]  rst_din,
   output logic [N-1:0]  dout,
   output logic [CW-1:0] shift_count,
   output logic          frame_done
);
   logic [N-1:0] sr;
   logic [N-1:0] shifted;
   for (genvar g = 0; g < L; g++) begin : g_lane
      // A one-bit lane has nothing to move; it just takes the serial input.
      if (M == 1) begin : g_one
         assign shifted[g*M] = scan_in[g];
      end else begin : g_many
         assign shifted[g*M +: M] = {sr[g*M +: M-1], scan_in[g]};
      end
      assign scan_out[g] = sr[g*M + M - 1];
   end
   assign frame_done = shift_count == CW'(M);
   always_ff @(posedge scan_clk) begin
      if (scan_rst) begin
         sr          <= rst_din;
         dout        <= rst_din;
         shift_count <= '0;
      end else begin
         if (update_en) dout <= sr;
         if (capture_en) begin
            sr          <= cap_din;
            shift_count <= '0;
         end else if (scan_en) begin
            sr          <= shifted;
            shift_count <= frame_done ? shift_count : shift_count + 1'b1;
         end
      end
   end
endmodule

// File: doc/scan_chain_lanes.md
SCAN_CHAIN_LANES -- requirements
Module: scan_chain_lanes

Interface
REQ-001 The module SHALL have parameter N, default 64, meaning the total scan register length in bits.
REQ-002 The module SHALL have parameter L, default 4, meaning the number of parallel scan lanes; N SHALL be an integer multiple of L, with lane length M = N/L and counter width CW = $clog2(M+1).
REQ-003 The module SHALL have port scan_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port scan_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port scan_en, input, 1 bit: shift enable.
REQ-006 The module SHALL have port scan_in, input, L bits: serial input, one bit per lane.
REQ-007 The module SHALL have port scan_out, output, L bits: serial output, one bit per lane.
REQ-008 The module SHALL have port capture_en, input, 1 bit: parallel load of cap_din into the shift register.
REQ-009 The module SHALL have port cap_din, input, N bits: capture data.
REQ-010 The module SHALL have port update_en, input, 1 bit: transfer of the shift register into dout.
REQ-011 The module SHALL have port rst_din, input, N bits: reset value for the shift register and dout.
REQ-012 The module SHALL have port dout, output, N bits: registered shadow output.
REQ-013 The module SHALL have port shift_count, output, CW bits: shifts performed since the last reset or capture.
REQ-014 The module SHALL have port frame_done, output, 1 bit: high when shift_count == M.

Function
REQ-015 Lane l SHALL own shift-register bits [l*M +: M]; scan_in[l] enters at bit l*M and scan_out[l] SHALL combinationally equal bit l*M+M-1.
REQ-016 A shift (scan_en=1, capture_en=0, scan_rst=0) SHALL move every lane one position toward its MSB in a single cycle, all lanes simultaneously.
REQ-017 capture_en=1 SHALL load cap_din into the shift register and clear shift_count to 0; capture SHALL take priority over a simultaneous scan_en.
REQ-018 update_en=1 SHALL load dout with the shift register value present before the same edge's shift or capture (one-cycle latency); dout SHALL otherwise hold.
REQ-019 shift_count SHALL increment by 1 per shift and saturate at M; update_en SHALL NOT change shift_count.
REQ-020 frame_done SHALL be combinational from shift_count and remain high while shift_count == M.
REQ-021 With scan_en=0 and capture_en=0, the shift register SHALL hold, and dout SHALL change only on update_en.
REQ-022 Priority per edge SHALL be: scan_rst > capture_en > scan_en; update_en is evaluated independently as in REQ-018.

Reset
REQ-023 On a scan_clk edge with scan_rst=1, the shift register and dout SHALL both load rst_din, and shift_count SHALL clear to 0, regardless of every other input.
REQ-024 A reset asserted mid-frame SHALL discard the partial frame; the first shift after reset deasserts SHALL count as shift 1.
REQ-025 After reset, scan_out SHALL reflect the lane MSBs of rst_din, and frame_done SHALL be 0 (for M >= 1).

Verification (N=8, L=2, M=4)
REQ-026 Reset with rst_din=8'hA5 -> dout=8'hA5, scan_out=2'b10, shift_count=0, frame_done=0.
REQ-027 4 shifts with scan_in=2'b01, update_en=0 -> shift register=8'h0F, dout stays 8'hA5, shift_count=4, frame_done=1; then a cycle with update_en=1 -> dout=8'h0F.
REQ-028 capture_en=1 and scan_en=1 in the same cycle with cap_din=8'h3C -> shift register=8'h3C, shift_count=0; then 4 shifts with scan_in=0 -> scan_out[0] sequence 1,1,0,0 and scan_out[1] sequence 0,0,1,1, with shift register=8'h00 at the end.
REQ-029 update_en=1 in the same cycle as a shift, from register=8'h0F with scan_in=2'b11 -> dout=8'h0F (pre-shift value), register=8'h1F.
REQ-030 6 consecutive shifts -> shift_count reads 1,2,3,4,4,4; frame_done asserts after the 4th shift and holds.
REQ-031 scan_rst=1 after 2 shifts, with rst_din=8'h00 -> shift register=8'h00, dout=8'h00, shift_count=0; the bench SHALL also check that inputs driven during the reset cycle are ignored.
